// File: rtl/issue_trace_collector.sv
// Issue-stage dispatch trace collector: multi-write capture FIFO
// draining one (pc, queue type) event per cycle to the file logger.
module issue_trace_collector #(
  parameter int N_QUEUES = 3,
  parameter int DEPTH    = 8,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trace_en,
  input  logic [N_QUEUES-1:0]       in_valid,
  input  logic [N_QUEUES-1:0]       in_ready,
  input  logic [32*N_QUEUES-1:0]    in_pc,
  output logic                      log_en,
  output logic [31:0]               log_pc,
  output logic [7:0]                log_queue_type,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic [CNT_W-1:0]          drop_cnt,
  output logic                      overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  qt;
  } entry_t;

  entry_t              mem [DEPTH];
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [N_QUEUES-1:0] fire;
  logic [N_QUEUES-1:0] take;
  logic [PW-1:0]       slot [N_QUEUES];
  logic [CW-1:0]       free;
  logic [CW-1:0]       acc;
  logic [CW-1:0]       drops;
  logic                pop;
  logic [CNT_W:0]      dsum;

  assign fire = in_valid & in_ready & {N_QUEUES{trace_en}};
  // Free space ignores this cycle's pop so accept logic stays off the drain path
  assign free = CW'(DEPTH) - fifo_count;
  assign pop  = fifo_count != '0;
  assign dsum = {1'b0, drop_cnt} + (CNT_W+1)'(drops);

  always_comb begin
    acc   = '0;
    drops = '0;
    take  = '0;
    for (int i = 0; i < N_QUEUES; i++) begin
      slot[i] = tail + acc[PW-1:0];
      if (fire[i]) begin
        if (acc < free) begin
          take[i] = 1'b1;
          acc     = acc + CW'(1);
        end else begin
          drops = drops + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      fifo_count     <= '0;
      log_en         <= 1'b0;
      log_pc         <= '0;
      log_queue_type <= '0;
      drop_cnt       <= '0;
      overflow       <= 1'b0;
    end else begin
      tail       <= tail + acc[PW-1:0];
      head       <= head + PW'(pop);
      fifo_count <= fifo_count + acc - CW'(pop);
      log_en     <= pop;
      if (pop) begin
        log_pc         <= mem[head].pc;
        log_queue_type <= mem[head].qt;
      end
      if (dsum[CNT_W]) drop_cnt <= '1;
      else             drop_cnt <= dsum[CNT_W-1:0];
      if (drops != '0) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_QUEUES; i++) begin
        if (take[i]) mem[slot[i]] <= {in_pc[32*i +: 32], 8'(i)};
      end
    end
  end

endmodule

// File: tb/tb_issue_trace_collector.sv
// Bench for issue_trace_collector: table vectors, directed
// corner sequences and random traffic against a queue model.
module tb_issue_trace_collector;

  localparam int N = 3;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            trace_en;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [31:0]     pcs [N];
  logic [32*N-1:0] in_pc;
  logic            log_en;
  logic [31:0]     log_pc;
  logic [7:0]      log_queue_type;
  logic [3:0]      fifo_count;
  logic [CNT_W-1:0] drop_cnt;
  logic            overflow;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) in_pc[32*i +: 32] = pcs[i];
  end

  issue_trace_collector #(.N_QUEUES(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .log_en(log_en), .log_pc(log_pc),
    .log_queue_type(log_queue_type), .fifo_count(fifo_count),
    .drop_cnt(drop_cnt), .overflow(overflow)
  );

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  qt;
  } ev_t;

  ev_t q[$];
  bit          m_en;
  logic [31:0] m_pc;
  logic [7:0]  m_qt;
  int          m_drop;
  bit          m_ovf;

  int n_vec = 0;
  int n_bad = 0;
  int n_logged = 0;
  int n_q2 = 0;
  int max_cnt = 0;

  // Behavioural model: queue of events, pop from the pre-edge
  // contents, accept up to (DEPTH - size before pop) new fires.
  task automatic model_edge();
    int pre, n, dr;
    ev_t e;
    if (rst) begin
      q.delete();
      m_en = 0; m_pc = 0; m_qt = 0; m_drop = 0; m_ovf = 0;
      return;
    end
    pre = q.size();
    if (pre > 0) begin
      e = q.pop_front();
      m_en = 1; m_pc = e.pc; m_qt = e.qt;
    end else begin
      m_en = 0;
    end
    n = 0; dr = 0;
    if (trace_en) begin
      for (int i = 0; i < N; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          if (n < DEPTH - pre) begin
            e.pc = pcs[i]; e.qt = 8'(i);
            q.push_back(e);
            n++;
          end else begin
            dr++;
          end
        end
      end
    end
    m_drop = m_drop + dr;
    if (m_drop > 65535) m_drop = 65535;
    if (dr > 0) m_ovf = 1;
  endtask

  task automatic cmp(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    cmp("log_en", log_en, m_en);
    if (m_en) begin
      cmp("log_pc", log_pc, m_pc);
      cmp("log_qt", log_queue_type, m_qt);
    end
    cmp("fifo_count", fifo_count, q.size());
    cmp("drop_cnt", drop_cnt, m_drop);
    cmp("overflow", overflow, m_ovf);
    if (log_en) n_logged++;
    if (log_en && log_queue_type == 8'd2) n_q2++;
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input bit r, input bit te, input logic [N-1:0] f,
                       input logic [31:0] p0, input logic [31:0] p1,
                       input logic [31:0] p2);
    rst = r; trace_en = te;
    in_valid = f; in_ready = f;
    pcs[0] = p0; pcs[1] = p1; pcs[2] = p2;
  endtask

  task automatic idle();
    drive(0, 1, 3'b000, 0, 0, 0);
  endtask

  typedef struct {
    bit          r;
    logic [2:0]  f;
    logic [31:0] p0, p1, p2;
    bit          e_en;
    logic [31:0] e_pc;
    logic [7:0]  e_qt;
    int          e_cnt;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int base_drop;
    drive(1, 1, 3'b000, 0, 0, 0);

    tbl[0] = '{1, 3'b000, 0, 0, 0, 0, 32'h0, 8'd0, 0};
    tbl[1] = '{0, 3'b000, 0, 0, 0, 0, 32'h0, 8'd0, 0};
    tbl[2] = '{0, 3'b010, 0, 32'h1c000010, 0, 0, 32'h0, 8'd0, 1};
    tbl[3] = '{0, 3'b000, 0, 0, 0, 1, 32'h1c000010, 8'd1, 0};
    tbl[4] = '{0, 3'b000, 0, 0, 0, 0, 32'h1c000010, 8'd1, 0};
    tbl[5] = '{0, 3'b111, 32'h100, 32'h200, 32'h300,
               0, 32'h1c000010, 8'd1, 3};
    tbl[6] = '{0, 3'b000, 0, 0, 0, 1, 32'h100, 8'd0, 2};
    tbl[7] = '{0, 3'b000, 0, 0, 0, 1, 32'h200, 8'd1, 1};
    tbl[8] = '{0, 3'b000, 0, 0, 0, 1, 32'h300, 8'd2, 0};
    tbl[9] = '{0, 3'b000, 0, 0, 0, 0, 32'h300, 8'd2, 0};

    for (int k = 0; k < 10; k++) begin
      drive(tbl[k].r, 1, tbl[k].f, tbl[k].p0, tbl[k].p1, tbl[k].p2);
      step();
      cmp("tbl_en", log_en, tbl[k].e_en);
      cmp("tbl_pc", log_pc, tbl[k].e_pc);
      cmp("tbl_qt", log_queue_type, tbl[k].e_qt);
      cmp("tbl_cnt", fifo_count, tbl[k].e_cnt);
      cmp("tbl_drop", drop_cnt, 0);
    end

    // Overflow: 12 fires over 4 cycles, 2 dropped
    drive(1, 1, 3'b000, 0, 0, 0); step();
    n_logged = 0;
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, 3'b111, 32'h1000 + c, 32'h2000 + c, 32'h3000 + c);
      step();
    end
    cmp("ovf_cnt", fifo_count, 7);
    cmp("ovf_drop", drop_cnt, 2);
    cmp("ovf_flag", overflow, 1);
    idle();
    for (int c = 0; c < 12; c++) step();
    cmp("ovf_logged", n_logged, 10);
    cmp("ovf_drop_eq", drop_cnt, 12 - n_logged);
    cmp("ovf_sticky", overflow, 1);

    // Wrap-around: 20 single fires, occupancy stays at 1
    drive(1, 1, 3'b000, 0, 0, 0); step();
    n_logged = 0; max_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      drive(0, 1, 3'b001, 32'h4000 + 4 * c, 0, 0);
      step();
    end
    idle(); step(); step();
    cmp("wrap_logged", n_logged, 20);
    cmp("wrap_maxcnt", max_cnt, 1);

    // trace_en gating
    drive(0, 1, 3'b011, 32'h5000, 32'h5004, 0); step();
    base_drop = int'(drop_cnt);
    n_logged = 0; n_q2 = 0;
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 3'b100, 0, 0, 32'h6000 + c);
      step();
    end
    idle(); step(); step();
    cmp("gate_logged", n_logged, 2);
    cmp("gate_q2", n_q2, 0);
    cmp("gate_drop", drop_cnt, base_drop);

    // Mid-operation reset with 5 buffered events
    drive(0, 1, 3'b111, 32'h7000, 32'h7004, 32'h7008); step();
    drive(0, 1, 3'b111, 32'h7010, 32'h7014, 32'h7018); step();
    cmp("mrst_pre", fifo_count, 5);
    drive(1, 1, 3'b111, 1, 2, 3); step();
    cmp("mrst_en", log_en, 0);
    cmp("mrst_cnt", fifo_count, 0);
    cmp("mrst_drop", drop_cnt, 0);
    cmp("mrst_ovf", overflow, 0);
    drive(0, 1, 3'b001, 32'h8000, 0, 0); step();
    idle(); step();
    cmp("mrst_post_en", log_en, 1);
    cmp("mrst_post_pc", log_pc, 32'h8000);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      trace_en = ($urandom_range(0, 7) != 0);
      in_valid = N'($urandom);
      in_ready = N'($urandom);
      for (int i = 0; i < N; i++) pcs[i] = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
